mem_burst_responder: RTL and testbench

Behavioural memory-side responder for the dram_tile controller_mem_* interface, used in memory-test SoC tops and simulation benches.
- Accepts single-beat and burst writes with byte masks.
- Accepts burst reads and returns read data at a fixed, parameterised latency.
- Sits where the controller's memory port terminates, with byte-masked backing storage inside.

---
 rtl/mem_resp_pkg.sv | 20 ++
 rtl/mem_resp_rd_pipe.sv | 44 ++++
 rtl/mem_burst_responder.sv | 150 +++++++++++++++
 tb/tb_mem_burst_responder.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types and helpers for mem_burst_responder.
// Optional build macro: MEM_RESP_BACKPRESSURE_EN (half-rate rdy in IDLE/WR_BURST).
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_BURST = 2'd2
    } state_e;

    function automatic bit params_ok(input int data_w, input int mask_w, input int rd_lat);
        return (mask_w * 8 == data_w) && (rd_lat >= 1);
    endfunction

    // A burst count of zero still moves one beat.
    function automatic int unsigned eff_burst(input int unsigned cnt);
        return (cnt == 0) ? 1 : cnt;
    endfunction

endpackage

// File: rtl/mem_resp_rd_pipe.sv
// Read-return delay line behind the storage array output register.
// Only valids are flushed by rst; the output word is zeroed so rd_data reads 0 in reset.
module mem_resp_rd_pipe #(
    parameter int DW     = 512,
    parameter int STAGES = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_val,
    input  logic [DW-1:0] in_data,
    output logic          out_val,
    output logic [DW-1:0] out_data
);

    if (STAGES == 0) begin : g_bypass
        assign out_val  = in_val;
        assign out_data = in_data;
    end else begin : g_pipe
        logic [STAGES-1:0]         vld_pipe;
        logic [STAGES-1:0][DW-1:0] data_pipe;

        // Data stages advance only behind a valid, so the output holds between beats.
        always_ff @(posedge clk) begin
            if (rst) begin
                vld_pipe <= '0;
            end else begin
                vld_pipe[0] <= in_val;
                for (int i = 1; i < STAGES; i++)
                    vld_pipe[i] <= vld_pipe[i-1];
            end
            if (in_val)
                data_pipe[0] <= in_data;
            for (int i = 1; i < STAGES; i++)
                if (vld_pipe[i-1])
                    data_pipe[i] <= data_pipe[i-1];
            if (rst)
                data_pipe[STAGES-1] <= '0;
        end

        assign out_val  = vld_pipe[STAGES-1];
        assign out_data = data_pipe[STAGES-1];
    end

endmodule

// File: rtl/mem_burst_responder.sv
// Memory-side responder for the controller_mem_* port: byte-masked storage, burst R/W.
// Define MEM_RESP_BACKPRESSURE_EN to make rdy toggle every cycle in IDLE/WR_BURST.
module mem_burst_responder
    import mem_resp_pkg::*;
#(
    parameter int MEM_ADDR_W      = 10,
    parameter int MEM_DATA_W      = 512,
    parameter int MEM_WR_MASK_W   = 64,
    parameter int MEM_BURST_CNT_W = 7,
    parameter int READ_LATENCY    = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       controller_mem_read_en,
    input  logic                       controller_mem_write_en,
    input  logic [MEM_ADDR_W-1:0]      controller_mem_addr,
    input  logic [MEM_DATA_W-1:0]      controller_mem_wr_data,
    input  logic [MEM_WR_MASK_W-1:0]   controller_mem_byte_en,
    input  logic [MEM_BURST_CNT_W-1:0] controller_mem_burst_cnt,
    output logic                       mem_controller_rdy,
    output logic                       mem_controller_rd_data_val,
    output logic [MEM_DATA_W-1:0]      mem_controller_rd_data
);

    localparam int DEPTH     = 1 << MEM_ADDR_W;
    localparam bit PARAMS_OK = params_ok(MEM_DATA_W, MEM_WR_MASK_W, READ_LATENCY);

    if (!PARAMS_OK) begin : g_bad_params
        $error("mem_burst_responder: MEM_WR_MASK_W*8 must equal MEM_DATA_W and READ_LATENCY >= 1");
    end

    state_e                     state_q, state_d;
    logic [MEM_ADDR_W-1:0]      next_addr_q, next_addr_d;
    logic [MEM_BURST_CNT_W-1:0] beats_left_q, beats_left_d;
    logic [MEM_BURST_CNT_W-1:0] first_left;
    logic                       base_rdy;
    logic                       acc_wr, acc_rd, rd_issue;
    logic [MEM_ADDR_W-1:0]      mem_addr;

    assign first_left = MEM_BURST_CNT_W'(eff_burst(32'(controller_mem_burst_cnt)) - 1);

`ifdef MEM_RESP_BACKPRESSURE_EN
    logic phase_q;

    // Phase is 0 in the first post-reset cycle, then alternates.
    always_ff @(posedge clk) begin
        if (rst) phase_q <= 1'b0;
        else     phase_q <= ~phase_q;
    end
    assign base_rdy = ~rst & phase_q;
`else
    assign base_rdy = ~rst;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            next_addr_q  <= '0;
            beats_left_q <= '0;
        end else begin
            state_q      <= state_d;
            next_addr_q  <= next_addr_d;
            beats_left_q <= beats_left_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        next_addr_d  = next_addr_q;
        beats_left_d = beats_left_q;
        case (state_q)
            IDLE: begin
                if (acc_wr || acc_rd) begin
                    beats_left_d = first_left;
                    next_addr_d  = controller_mem_addr + 1'b1;
                    if (first_left != '0)
                        state_d = acc_wr ? WR_BURST : RD_BURST;
                end
            end
            WR_BURST, RD_BURST: begin
                if (acc_wr || rd_issue) begin
                    next_addr_d  = next_addr_q + 1'b1;
                    beats_left_d = beats_left_q - 1'b1;
                    if (beats_left_q == MEM_BURST_CNT_W'(1))
                        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Write wins a simultaneous request in IDLE; read_en is ignored mid write burst.
    always_comb begin
        mem_controller_rdy = 1'b0;
        acc_wr             = 1'b0;
        acc_rd             = 1'b0;
        rd_issue           = 1'b0;
        mem_addr           = next_addr_q;
        case (state_q)
            IDLE: begin
                mem_controller_rdy = base_rdy;
                acc_wr             = controller_mem_write_en & base_rdy;
                acc_rd             = controller_mem_read_en & ~controller_mem_write_en & base_rdy;
                rd_issue           = acc_rd;
                mem_addr           = controller_mem_addr;
            end
            WR_BURST: begin
                mem_controller_rdy = base_rdy;
                acc_wr             = controller_mem_write_en & base_rdy;
            end
            RD_BURST: rd_issue = ~rst;
            default: ;
        endcase
    end

    logic [MEM_DATA_W-1:0] mem [0:DEPTH-1];
    logic                  arr_val;
    logic [MEM_DATA_W-1:0] arr_data;

    always_ff @(posedge clk) begin
        if (acc_wr)
            for (int b = 0; b < MEM_WR_MASK_W; b++)
                if (controller_mem_byte_en[b])
                    mem[mem_addr][b*8 +: 8] <= controller_mem_wr_data[b*8 +: 8];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            arr_val  <= 1'b0;
            arr_data <= '0;
        end else begin
            arr_val <= rd_issue;
            if (rd_issue)
                arr_data <= mem[mem_addr];
        end
    end

    mem_resp_rd_pipe #(
        .DW     (MEM_DATA_W),
        .STAGES (READ_LATENCY - 1)
    ) u_rd_pipe (
        .clk      (clk),
        .rst      (rst),
        .in_val   (arr_val),
        .in_data  (arr_data),
        .out_val  (mem_controller_rd_data_val),
        .out_data (mem_controller_rd_data)
    );

endmodule

// File: tb/tb_mem_burst_responder.sv
// Directed bench for mem_burst_responder; honours MEM_RESP_BACKPRESSURE_EN when defined.
module tb_mem_burst_responder;
    localparam int AW = 10, DW = 512, MW = 64, BW = 7, RL = 2;

    logic          clk = 1'b0, rst = 1'b1, re = 1'b0, we = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;
    logic [MW-1:0] be = '0;
    logic [BW-1:0] bcnt = '0;
    logic          rdy, val;
    logic [DW-1:0] rdata;

    mem_burst_responder #(
        .MEM_ADDR_W(AW), .MEM_DATA_W(DW), .MEM_WR_MASK_W(MW),
        .MEM_BURST_CNT_W(BW), .READ_LATENCY(RL)
    ) dut (
        .clk(clk), .rst(rst),
        .controller_mem_read_en(re), .controller_mem_write_en(we),
        .controller_mem_addr(addr), .controller_mem_wr_data(wdata),
        .controller_mem_byte_en(be), .controller_mem_burst_cnt(bcnt),
        .mem_controller_rdy(rdy), .mem_controller_rd_data_val(val),
        .mem_controller_rd_data(rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] rq[$];
    int            rc[$];
    always @(negedge clk) if (val) begin rq.push_back(rdata); rc.push_back(cyc); end

    int n_chk = 0, n_pass = 0;
    int acc_cyc, last_acc, start_cyc;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_rdy(input string tag);
        for (int i = 0; i < 40 && !rdy; i++) tick();
        if (!rdy) check({tag, "_rdy_timeout"}, 0, 1);
    endtask

    task automatic write_words(input logic [AW-1:0] a, input int n, input logic [DW-1:0] d0,
                               input logic [MW-1:0] m);
        for (int i = 0; i < n; i++) begin
            we = 1'b1; addr = a; wdata = d0 + DW'(i); be = m; bcnt = BW'(n);
            wait_rdy("wr");
            last_acc = cyc;
            tick();
        end
        we = 1'b0;
    endtask

    task automatic rd_cmd(input logic [AW-1:0] a, input int n);
        re = 1'b1; addr = a; bcnt = BW'(n);
        wait_rdy("rd");
        acc_cyc = cyc;
        tick();
        re = 1'b0;
    endtask

    task automatic check_reads(input string tag, input int n, input logic [DW-1:0] d0);
        check({tag, "_cnt"}, DW'(rq.size()), DW'(n));
        for (int i = 0; i < n && i < rq.size(); i++) begin
            check($sformatf("%s_data%0d", tag, i), rq[i], d0 + DW'(i));
            check($sformatf("%s_cyc%0d", tag, i), DW'(rc[i]), DW'(acc_cyc + RL + i));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    logic [DW-1:0] pat_a5, exp_mask;

    initial begin
        pat_a5   = {64{8'hA5}};
        exp_mask = {{63{8'hFF}}, 8'h00};

        tick(); tick();
        check("rst_rdy", DW'(rdy), 0);
        check("rst_val", DW'(val), 0);
        check("rst_data", rdata, 0);
        rst = 1'b0; #1;
`ifdef MEM_RESP_BACKPRESSURE_EN
        check("post_rst_rdy", DW'(rdy), 0);
        // Three beats with write_en held: accepted on alternating cycles only.
        start_cyc = cyc;
        write_words(10'h050, 3, DW'(8'h77), '1);
        check("bp_wr_cycles", DW'(last_acc - start_cyc + 1), 6);
        rq.delete(); rc.delete();
        rd_cmd(10'h050, 3); idle(RL + 4);
        check_reads("bp_rd", 3, DW'(8'h77));
`else
        check("post_rst_rdy", DW'(rdy), 1);
`endif

        // Single write then single read.
        write_words(10'h010, 1, pat_a5, '1);
        rq.delete(); rc.delete();
        rd_cmd(10'h010, 1); idle(RL + 3);
        check_reads("single", 1, pat_a5);

        // Write burst across the top address, then read it back.
        write_words(10'h3FE, 4, DW'(1), '1);
        rq.delete(); rc.delete();
        rd_cmd(10'h3FE, 4);
        check("rdb_rdy0", DW'(rdy), 0); tick();
        check("rdb_rdy1", DW'(rdy), 0); tick();
        check("rdb_rdy2", DW'(rdy), 0); tick();
`ifndef MEM_RESP_BACKPRESSURE_EN
        check("rdb_rdy_back", DW'(rdy), 1);
`endif
        idle(RL + 3);
        check_reads("wrap", 4, DW'(1));
        rq.delete(); rc.delete();
        rd_cmd(10'h000, 2); idle(RL + 4);
        check_reads("wrap_low", 2, DW'(3));

        // Partial byte mask.
        write_words(10'h020, 1, '1, '1);
        write_words(10'h020, 1, '0, MW'(1));
        rq.delete(); rc.delete();
        rd_cmd(10'h020, 1); idle(RL + 3);
        check_reads("mask", 1, exp_mask);

        // Simultaneous read+write: only the write is taken.
        write_words(10'h030, 1, DW'(16'hBEEF), '1);
        rq.delete(); rc.delete();
        re = 1'b1; we = 1'b1; addr = 10'h030; wdata = DW'(16'hCAFE); be = '1; bcnt = BW'(1);
        wait_rdy("rw");
        tick();
        we = 1'b0;
        wait_rdy("rw_rd");
        acc_cyc = cyc;
        tick();
        re = 1'b0;
        idle(RL + 3);
        check_reads("rw", 1, DW'(16'hCAFE));

        // Reset in the second cycle of a 4-beat read burst.
        write_words(10'h040, 4, DW'(8'h11), '1);
        rq.delete(); rc.delete();
        rd_cmd(10'h040, 4);
        rst = 1'b1;
        tick();
        rst = 1'b0; #1;
        check("mid_rst_val", DW'(val), 0);
        check("mid_rst_data", rdata, 0);
        idle(6);
        check("mid_rst_stray", DW'(rq.size()), 0);
        rq.delete(); rc.delete();
        rd_cmd(10'h041, 1); idle(RL + 3);
        check_reads("after_rst", 1, DW'(8'h12));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
